// File: rtl/frame_task_scheduler_pkg.sv
// Shared types and helpers for the frame task scheduler and its round-robin arbiter.
package frame_task_scheduler_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DISPATCH = 3'd1,
    DRAIN    = 3'd2,
    WAIT_DC  = 3'd3,
    WAIT_VGA = 3'd4,
    SWITCH   = 3'd5
  } sched_state_e;

  // Round-robin successor of a unit index, wrapping at the unit count.
  function automatic int next_rr(input int idx, input int units);
    return (idx + 1 >= units) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/frame_task_scheduler_if.sv
// Task/frame handshake bundle between the scheduler and the object buffer, rasterizers, depth comparator and vga.
interface frame_task_scheduler_if #(
  parameter int UNITS       = 4,
  parameter int FRAME_CNT_W = 16
);
  logic                   read_end;
  logic [UNITS-1:0]       unit_ready;
  logic [UNITS-1:0]       task_complete;
  logic                   dc_all_complete;
  logic                   vga_complete;
  logic                   next_task;
  logic [UNITS-1:0]       unit_issue;
  logic                   switch_buffer;
  logic [UNITS-1:0]       busy_units;
  logic [FRAME_CNT_W-1:0] frame_count;
  logic                   protocol_error;

  modport master (
    input  read_end, unit_ready, task_complete, dc_all_complete, vga_complete,
    output next_task, unit_issue, switch_buffer, busy_units, frame_count, protocol_error
  );

  modport slave (
    output read_end, unit_ready, task_complete, dc_all_complete, vga_complete,
    input  next_task, unit_issue, switch_buffer, busy_units, frame_count, protocol_error
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr (wrapping) wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_vld
);

  int idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_vld = 1'b0;
    idx       = 0;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!grant_vld && req[idx]) begin
        grant_vld      = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/frame_task_scheduler.sv
// Issues object-buffer tasks to idle rasterizer units round-robin and sequences the end of each frame.
//   state    | meaning
//   IDLE     | one cycle after reset release
//   DISPATCH | issue tasks until read_end
//   DRAIN    | wait for all units to finish
//   WAIT_DC  | wait for depth comparator to flush
//   WAIT_VGA | wait for end of scanned-out frame
//   SWITCH   | swap buffers, count frame
module frame_task_scheduler
  import frame_task_scheduler_pkg::*;
#(
  parameter int UNITS       = 4,
  parameter bit VSYNC_LOCK  = 1'b1,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  frame_task_scheduler_if.master bus
);

  localparam int PW = (UNITS > 1) ? $clog2(UNITS) : 1;

  sched_state_e           state_q, state_d;
  logic [UNITS-1:0]       busy_q, busy_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [FRAME_CNT_W-1:0] frame_count_q, frame_count_d;
  logic                   protocol_error_q, protocol_error_d;

  logic [UNITS-1:0]       eligible;
  logic [UNITS-1:0]       grant;
  logic [PW-1:0]          grant_idx;
  logic                   grant_vld;
  logic                   issue;

  assign eligible = bus.unit_ready & ~busy_q;

  rr_arbiter #(.N(UNITS), .IW(PW)) u_arb (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld)
  );

  assign issue = (state_q == DISPATCH) && !bus.read_end && grant_vld;

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    frame_count_d    = frame_count_q;
    // A completion clears busy in every state; one for an idle unit is a protocol violation.
    busy_d           = (busy_q & ~bus.task_complete) | (issue ? grant : '0);
    protocol_error_d = protocol_error_q | (|(bus.task_complete & ~busy_q));

    case (state_q)
      IDLE:     state_d = DISPATCH;
      DISPATCH: begin
        if (issue) begin
          rr_ptr_d = PW'(next_rr(int'(grant_idx), UNITS));
        end else if (bus.read_end) begin
          state_d = DRAIN;
        end
      end
      DRAIN:    if (busy_q == '0) state_d = WAIT_DC;
      WAIT_DC:  if (bus.dc_all_complete) state_d = VSYNC_LOCK ? WAIT_VGA : SWITCH;
      WAIT_VGA: if (bus.vga_complete) state_d = SWITCH;
      SWITCH: begin
        frame_count_d = frame_count_q + FRAME_CNT_W'(1);
        rr_ptr_d      = '0;
        state_d       = DISPATCH;
      end
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q          <= IDLE;
      busy_q           <= '0;
      rr_ptr_q         <= '0;
      frame_count_q    <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      busy_q           <= busy_d;
      rr_ptr_q         <= rr_ptr_d;
      frame_count_q    <= frame_count_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  assign bus.next_task      = issue;
  assign bus.unit_issue     = issue ? grant : '0;
  assign bus.switch_buffer  = (state_q == SWITCH);
  assign bus.busy_units     = busy_q;
  assign bus.frame_count    = frame_count_q;
  assign bus.protocol_error = protocol_error_q;

endmodule

// File: tb/tb_frame_task_scheduler.sv
// Self-checking bench: per-cycle vector table, hand-written frame-end sequences and a random run against a reference model.
module tb_frame_task_scheduler;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst_a, rst_b;
  int   vectors = 0;
  int   miscompares = 0;

  frame_task_scheduler_if #(.UNITS(4), .FRAME_CNT_W(16)) bus_a ();
  frame_task_scheduler_if #(.UNITS(4), .FRAME_CNT_W(4))  bus_b ();

  frame_task_scheduler #(.UNITS(4), .VSYNC_LOCK(1'b1), .FRAME_CNT_W(16)) dut_a (
    .clock (clock), .reset (rst_a), .bus (bus_a)
  );

  frame_task_scheduler #(.UNITS(4), .VSYNC_LOCK(1'b0), .FRAME_CNT_W(4)) dut_b (
    .clock (clock), .reset (rst_b), .bus (bus_b)
  );

  // {next_task, unit_issue, switch_buffer, busy_units, frame_count, protocol_error}
  typedef struct {
    bit         rst_first;
    bit         re;
    logic [3:0] rdy;
    logic [3:0] tc;
    bit         dc;
    bit         vga;
    bit         nt;
    logic [3:0] iss;
    bit         sw;
    logic [3:0] busy;
    logic [15:0] fc;
    bit         perr;
  } vec_t;

  vec_t tbl[$];

  typedef enum int {M_START, M_ISSUE, M_DRAIN, M_DC, M_VGA, M_FLIP} mphase_e;

  function automatic logic [26:0] pack_a();
    return {bus_a.next_task, bus_a.unit_issue, bus_a.switch_buffer, bus_a.busy_units,
            bus_a.frame_count, bus_a.protocol_error};
  endfunction

  function automatic logic [26:0] pack_b();
    return {12'd0, bus_b.next_task, bus_b.unit_issue, bus_b.switch_buffer, bus_b.busy_units,
            bus_b.frame_count, bus_b.protocol_error};
  endfunction

  task automatic check(input string name, input logic [26:0] got, input logic [26:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic drive_a(input bit re, input logic [3:0] rdy, input logic [3:0] tc,
                         input bit dc, input bit vga);
    bus_a.read_end        = re;
    bus_a.unit_ready      = rdy;
    bus_a.task_complete   = tc;
    bus_a.dc_all_complete = dc;
    bus_a.vga_complete    = vga;
  endtask

  task automatic reset_a();
    rst_a = 1'b0;
    drive_a(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    #1 check("reset_state", pack_a(), 27'd0);
    @(negedge clock);
    rst_a = 1'b1;
  endtask

  task automatic add(input bit rf, input bit re, input logic [3:0] rdy, input logic [3:0] tc,
                     input bit dc, input bit vga, input bit nt, input logic [3:0] iss,
                     input bit sw, input logic [3:0] busy, input logic [15:0] fc, input bit perr);
    vec_t v;
    v.rst_first = rf; v.re = re; v.rdy = rdy; v.tc = tc; v.dc = dc; v.vga = vga;
    v.nt = nt; v.iss = iss; v.sw = sw; v.busy = busy; v.fc = fc; v.perr = perr;
    tbl.push_back(v);
  endtask

  initial begin
    int          nsw;
    bit          esw;
    bit          sw_seen;
    mphase_e     ph;
    logic [3:0]  mbusy;
    int          mrr;
    int          mfc;
    bit          mperr;

    rst_a = 1'b0;
    rst_b = 1'b0;
    drive_a(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    bus_b.read_end        = 1'b1;
    bus_b.unit_ready      = 4'h0;
    bus_b.task_complete   = 4'h0;
    bus_b.dc_all_complete = 1'b1;
    bus_b.vga_complete    = 1'b0;

    // Empty frames, no vsync lock: switch every 4 cycles, 4-bit frame counter wraps 15 -> 0
    repeat (2) @(negedge clock);
    #1 check("reset_b", pack_b(), 27'd0);
    @(negedge clock);
    rst_b = 1'b1;
    nsw = 0;
    for (int i = 0; i < 72; i++) begin
      esw = (i >= 4) && (i % 4 == 0);
      #1 check($sformatf("empty_frame c%0d", i), pack_b(),
               {12'd0, 1'b0, 4'h0, esw, 4'h0, 4'(nsw), 1'b0});
      if (esw) nsw++;
      @(negedge clock);
    end

    // Six tasks on four ready units, then a 4-unit ready=1010 sequence with a bogus completion
    add(1,0,4'hF,4'h0,1,0, 0,4'h0,0,4'h0,16'd0,0);
    add(0,0,4'hF,4'h0,1,0, 1,4'h1,0,4'h0,16'd0,0);
    add(0,0,4'hF,4'h0,1,0, 1,4'h2,0,4'h1,16'd0,0);
    add(0,0,4'hF,4'h0,1,0, 1,4'h4,0,4'h3,16'd0,0);
    add(0,0,4'hF,4'h0,1,0, 1,4'h8,0,4'h7,16'd0,0);
    add(0,0,4'hF,4'h0,1,0, 0,4'h0,0,4'hF,16'd0,0);
    add(0,0,4'hF,4'h1,1,0, 0,4'h0,0,4'hF,16'd0,0);
    add(0,0,4'hF,4'h0,1,0, 1,4'h1,0,4'hE,16'd0,0);
    add(0,0,4'hF,4'h2,1,0, 0,4'h0,0,4'hF,16'd0,0);
    add(0,0,4'hF,4'h0,1,0, 1,4'h2,0,4'hD,16'd0,0);
    add(0,1,4'hF,4'hF,1,0, 0,4'h0,0,4'hF,16'd0,0);
    add(0,1,4'hF,4'h0,1,0, 0,4'h0,0,4'h0,16'd0,0);
    add(0,1,4'hF,4'h0,1,0, 0,4'h0,0,4'h0,16'd0,0);
    add(0,1,4'hF,4'h0,1,0, 0,4'h0,0,4'h0,16'd0,0);
    add(0,1,4'hF,4'h0,1,1, 0,4'h0,0,4'h0,16'd0,0);
    add(0,0,4'hF,4'h0,1,0, 0,4'h0,1,4'h0,16'd0,0);
    add(0,0,4'hF,4'h0,1,0, 1,4'h1,0,4'h0,16'd1,0);
    add(0,1,4'hF,4'h0,1,0, 0,4'h0,0,4'h1,16'd1,0);
    add(1,0,4'hA,4'h0,1,0, 0,4'h0,0,4'h0,16'd0,0);
    add(0,0,4'hA,4'h0,1,0, 1,4'h2,0,4'h0,16'd0,0);
    add(0,0,4'hA,4'h0,1,0, 1,4'h8,0,4'h2,16'd0,0);
    add(0,0,4'hA,4'h2,1,0, 0,4'h0,0,4'hA,16'd0,0);
    add(0,0,4'hA,4'h0,1,0, 1,4'h2,0,4'h8,16'd0,0);
    add(0,0,4'hA,4'h4,1,0, 0,4'h0,0,4'hA,16'd0,0);
    add(0,1,4'hA,4'h0,1,0, 0,4'h0,0,4'hA,16'd0,1);
    add(0,1,4'hA,4'hA,1,0, 0,4'h0,0,4'hA,16'd0,1);
    add(0,1,4'hA,4'h0,1,0, 0,4'h0,0,4'h0,16'd0,1);

    foreach (tbl[r]) begin
      if (tbl[r].rst_first) reset_a();
      drive_a(tbl[r].re, tbl[r].rdy, tbl[r].tc, tbl[r].dc, tbl[r].vga);
      #1 check($sformatf("table row %0d", r), pack_a(),
               {tbl[r].nt, tbl[r].iss, tbl[r].sw, tbl[r].busy, tbl[r].fc, tbl[r].perr});
      @(negedge clock);
    end

    // Asynchronous reset in the middle of DRAIN with units 1 and 2 busy
    reset_a();
    drive_a(1'b0, 4'h6, 4'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clock);
    bus_a.read_end = 1'b1;
    @(negedge clock);
    #1 check("drain busy", {23'd0, bus_a.busy_units}, 27'h6);
    #1 rst_a = 1'b0;
    #1 check("async reset", pack_a(), 27'd0);
    @(negedge clock);
    rst_a = 1'b1;
    drive_a(1'b0, 4'hF, 4'h0, 1'b0, 1'b0);
    @(negedge clock);
    #1 check("post-reset issue", {22'd0, bus_a.next_task, bus_a.unit_issue}, {22'd0, 1'b1, 4'h1});

    // Vsync lock: early vga pulse ignored, switch exactly one cycle after the real one
    reset_a();
    drive_a(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    repeat (2) @(negedge clock);
    bus_a.vga_complete = 1'b1;
    @(negedge clock);
    bus_a.vga_complete = 1'b0;
    bus_a.read_end     = 1'b1;
    #1 check("early vga", {26'd0, bus_a.switch_buffer}, 27'd0);
    repeat (3) @(negedge clock);
    bus_a.dc_all_complete = 1'b1;
    sw_seen = 1'b0;
    repeat (200) begin
      @(negedge clock);
      #1 if (bus_a.switch_buffer) sw_seen = 1'b1;
    end
    check("no switch before vga", {26'd0, sw_seen}, 27'd0);
    bus_a.vga_complete = 1'b1;
    @(negedge clock);
    bus_a.vga_complete = 1'b0;
    #1 check("vga switch", {10'd0, bus_a.switch_buffer, bus_a.frame_count}, {10'd0, 1'b1, 16'd0});
    @(negedge clock);
    #1 check("vga after", {10'd0, bus_a.switch_buffer, bus_a.frame_count}, {10'd0, 1'b0, 16'd1});

    // Random traffic against the reference model
    reset_a();
    ph = M_START; mbusy = 4'h0; mrr = 0; mfc = 0; mperr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bit         re, dc, vga, all_idle;
      logic [3:0] rdy, tc, iss;
      int         k_iss;
      re  = (ph == M_ISSUE) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      rdy = 4'($urandom);
      tc  = 4'($urandom) & 4'($urandom) & mbusy;
      if (ph != M_ISSUE && $urandom_range(0, 199) == 0) tc = tc | (4'b0001 << $urandom_range(0, 3));
      dc  = ($urandom_range(0, 3) != 0);
      vga = ($urandom_range(0, 5) == 0);
      drive_a(re, rdy, tc, dc, vga);

      k_iss = -1;
      if (ph == M_ISSUE && !re) begin
        for (int i = 0; i < 4; i++) begin
          int k;
          k = (mrr + i) % 4;
          if (k_iss < 0 && rdy[k] && !mbusy[k]) k_iss = k;
        end
      end
      iss = (k_iss >= 0) ? (4'b0001 << k_iss) : 4'h0;
      #1 check($sformatf("random c%0d", c), pack_a(),
               {k_iss >= 0, iss, ph == M_FLIP, mbusy, 16'(mfc), mperr});

      all_idle = (mbusy == 4'h0);
      for (int k = 0; k < 4; k++) begin
        if (tc[k]) begin
          if (!mbusy[k]) mperr = 1'b1;
          mbusy[k] = 1'b0;
        end
      end
      if (k_iss >= 0) begin
        mbusy[k_iss] = 1'b1;
        mrr = (k_iss + 1) % 4;
      end
      case (ph)
        M_START: ph = M_ISSUE;
        M_ISSUE: if (k_iss < 0 && re) ph = M_DRAIN;
        M_DRAIN: if (all_idle) ph = M_DC;
        M_DC:    if (dc) ph = M_VGA;
        M_VGA:   if (vga) ph = M_FLIP;
        default: begin
          mfc = mfc + 1;
          mrr = 0;
          ph  = M_ISSUE;
        end
      endcase
      @(negedge clock);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
